// File: rtl/link_pkg.sv
// Shared constants, state types and packet helpers for the board-to-board
// player-state link.
package link_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hFF;
    localparam int         PKT_LEN   = 5;

    typedef enum logic {IDLE, SEND}    tx_state_t;
    typedef enum logic {HUNT, COLLECT} rx_state_t;

    function automatic logic [1:0] link_chk(
        input logic [11:0] x,
        input logic [11:0] y,
        input logic [1:0]  btn
    );
        return x[1:0] ^ y[1:0] ^ btn;
    endfunction

    // Payload bytes keep bit7 clear so SYNC_BYTE can never alias data.
    function automatic logic [7:0] link_byte(
        input logic [2:0]  idx,
        input logic [11:0] x,
        input logic [11:0] y,
        input logic [1:0]  btn
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = {1'b0, x[11:5]};
            3'd2:    b = {1'b0, x[4:0], y[11:10]};
            3'd3:    b = {1'b0, y[9:3]};
            3'd4:    b = {1'b0, y[2:0], btn, link_chk(x, y, btn)};
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_link_rx.sv
// Receive side of the player link: packet parser, error counter and
// link-alive timer.
module uart_link_rx
    import link_pkg::*;
#(
    parameter int LINK_TIMEOUT = 8_000_000,
    parameter int TO_W         = $clog2(LINK_TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_empty,
    input  logic [7:0]  r_data,
    output logic        rd_uart,
    output logic [11:0] xpos_remote,
    output logic [11:0] ypos_remote,
    output logic [1:0]  btn_remote,
    output logic        remote_valid,
    output logic        link_up,
    output logic [7:0]  rx_err_cnt
);

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(LINK_TIMEOUT);

    rx_state_t       state, state_nx;
    logic [1:0]      cnt, cnt_nx;
    logic [20:0]     pay, pay_nx;
    logic [27:0]     full;
    logic            good, err_ev;
    logic [TO_W-1:0] timer;

    assign rd_uart = !rx_empty;
    assign full    = {pay, r_data[6:0]};

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pay_nx   = pay;
        good     = 1'b0;
        err_ev   = 1'b0;
        if (!rx_empty) begin
            unique case (state)
                HUNT: begin
                    if (r_data == SYNC_BYTE) begin
                        state_nx = COLLECT;
                        cnt_nx   = 2'd0;
                    end
                end
                COLLECT: begin
                    if (r_data == SYNC_BYTE) begin
                        cnt_nx = 2'd0;
                        err_ev = 1'b1;
                    end else if (r_data[7]) begin
                        state_nx = HUNT;
                        err_ev   = 1'b1;
                    end else if (cnt == 2'd3) begin
                        state_nx = HUNT;
                        if (link_chk(full[27:16], full[15:4], full[3:2]) == full[1:0])
                            good = 1'b1;
                        else
                            err_ev = 1'b1;
                    end else begin
                        pay_nx = {pay[13:0], r_data[6:0]};
                        cnt_nx = cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= HUNT;
            cnt          <= '0;
            pay          <= '0;
            xpos_remote  <= '0;
            ypos_remote  <= '0;
            btn_remote   <= '0;
            remote_valid <= 1'b0;
            link_up      <= 1'b0;
            rx_err_cnt   <= '0;
            timer        <= '0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            pay          <= pay_nx;
            remote_valid <= good;
            if (good) begin
                xpos_remote <= full[27:16];
                ypos_remote <= full[15:4];
                btn_remote  <= full[3:2];
            end
            if (err_ev && rx_err_cnt != 8'hFF)
                rx_err_cnt <= rx_err_cnt + 8'd1;
            // Timer parks at TO_MAX so link_up stays down until a good packet.
            if (good) begin
                timer   <= '0;
                link_up <= 1'b1;
            end else if (timer != TO_MAX) begin
                timer <= timer + 1'b1;
                if (timer == TO_MAX - 1'b1)
                    link_up <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_link_ctl.sv
// Player-state link scheduler: per-frame TX packet writer plus the RX
// parser, both talking to the UART FIFO pair.
module uart_link_ctl
    import link_pkg::*;
#(
    parameter int LINK_TIMEOUT = 8_000_000,
    parameter int TO_W         = $clog2(LINK_TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        v_tick,
    input  logic [11:0] xpos_local,
    input  logic [11:0] ypos_local,
    input  logic [1:0]  btn_local,
    input  logic        tx_full,
    output logic        wr_uart,
    output logic [7:0]  w_data,
    input  logic        rx_empty,
    input  logic [7:0]  r_data,
    output logic        rd_uart,
    output logic [11:0] xpos_remote,
    output logic [11:0] ypos_remote,
    output logic [1:0]  btn_remote,
    output logic        remote_valid,
    output logic        link_up,
    output logic [7:0]  rx_err_cnt
);

    tx_state_t   state, state_nx;
    logic [2:0]  idx, idx_nx;
    logic        pending, pending_nx;
    logic        snap;
    logic        v_q, v_rise;
    logic [11:0] px, py;
    logic [1:0]  pb;

    assign v_rise = v_tick && !v_q;

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        pending_nx = pending;
        snap       = 1'b0;
        wr_uart    = 1'b0;
        w_data     = 8'h00;
        unique case (state)
            IDLE: begin
                if (v_rise) begin
                    snap     = 1'b1;
                    state_nx = SEND;
                    idx_nx   = 3'd0;
                end
            end
            SEND: begin
                if (v_rise)
                    pending_nx = 1'b1;
                if (!tx_full) begin
                    wr_uart = 1'b1;
                    w_data  = link_byte(idx, px, py, pb);
                    if (idx == 3'(PKT_LEN - 1)) begin
                        idx_nx = 3'd0;
                        // An edge on the last byte counts as pending too.
                        if (pending || v_rise) begin
                            snap       = 1'b1;
                            pending_nx = 1'b0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        idx_nx = idx + 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= 1'b0;
            v_q     <= 1'b0;
            px      <= '0;
            py      <= '0;
            pb      <= '0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            pending <= pending_nx;
            v_q     <= v_tick;
            if (snap) begin
                px <= xpos_local;
                py <= ypos_local;
                pb <= btn_local;
            end
        end
    end

    uart_link_rx #(
        .LINK_TIMEOUT (LINK_TIMEOUT),
        .TO_W         (TO_W)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_empty     (rx_empty),
        .r_data       (r_data),
        .rd_uart      (rd_uart),
        .xpos_remote  (xpos_remote),
        .ypos_remote  (ypos_remote),
        .btn_remote   (btn_remote),
        .remote_valid (remote_valid),
        .link_up      (link_up),
        .rx_err_cnt   (rx_err_cnt)
    );

endmodule
